output_argmax: RTL
==================

Name: output_argmax

Overview:
- Downstream of the output-layer neuron array; consumes the packed output_neuron values of all output neurons.
- Sequentially scans these values and reports the index of the largest one as the recognised digit.
- Provides a single-cycle done pulse plus a held result/valid pair for the display/UART stage.
- Input vector is snapshotted at start, so upstream neurons may change their outputs during the scan.

Parameters:
- num_classes, 10, number of output neurons/classes scanned (>=1).
- resolution, 8, bit width of each neuron output, two's-complement signed.
- index_width, max(1,$clog2(num_classes)), width of the digit index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request to classify; sampled only in IDLE.
- neuron_data  input  resolution*num_classes  packed neuron outputs; class i at bits [resolution*(i+1)-1 : resolution*i].
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when the result becomes valid.
- digit  output  index_width  index of the maximum value.
- max_value  output  resolution  signed maximum value found.
- result_valid  output  1  high from done until next accepted start or reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, result_valid, digit, max_value, scan index and snapshot register are all cleared to 0.
  - Reset mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1:
    - Snapshot neuron_data.
    - best_val <= class 0, best_idx <= 0, idx <= 1.
    - result_valid <= 0.
    - Next state is SCAN, or DONE directly if num_classes==1.
  - start=0 holds IDLE; digit, max_value and result_valid are held.
- SCAN:
  - Each cycle compares snapshot[idx] against best_val using a signed comparison.
  - Replace best only if strictly greater, so ties resolve to the lowest index.
  - idx increments each cycle.
  - On the edge processing idx==num_classes-1, update best, then:
    - State goes to DONE.
    - done <= 1, result_valid <= 1.
    - digit <= final best_idx, max_value <= final best_val.
- DONE:
  - Lasts exactly one cycle; the next edge returns to IDLE with done <= 0.
- Latency:
  - start sampled at edge k gives done high during the cycle following edge k+num_classes-1.
  - For num_classes=10, done appears 9 cycles after the start edge.
  - For num_classes=1, done appears in the cycle immediately after the start edge.
- start while busy (SCAN or DONE) is ignored and not queued.
  - Back-to-back operation: start may be asserted in the first IDLE cycle after DONE.
- neuron_data changes after the start edge do not affect the result.
- Index counter width is index_width. It never exceeds num_classes-1, so there is no wrap-around.
- Arithmetic: compare only; no overflow is possible. max_value is the raw resolution-bit value.

Test Plan:
- Basic: num_classes=10, resolution=8, data = {0,5,-3,100,7,99,-128,2,1,0}, start pulse
  -> done 9 cycles later, digit=3, max_value=100, result_valid=1 held afterwards.
- Ties and negatives:
  - Data all -5 -> digit=0, max_value=-5.
  - Data with 127 at indices 4 and 8 -> digit=4.
  - Data with -128 everywhere except -127 at index 9 -> digit=9.
- Snapshot/ignore:
  - Change neuron_data and pulse start during SCAN -> result uses the original data, exactly one done pulse, busy continuous until DONE.
- Reset mid-scan:
  - reset=0 asserted 4 cycles after start -> all outputs 0 immediately (asynchronous).
  - After release, no done pulse; a new start completes normally.
- Back-to-back:
  - Start held high continuously -> done every 11 cycles (start edge, 9 SCAN, DONE, IDLE re-accept).
  - result_valid drops on each accepted start; digit tracks each new data set.
- Degenerate: num_classes=1, data=-7 -> done the cycle after the start edge, digit=0, max_value=-7.

Source files
------------

// File: rtl/output_argmax.sv
// output_argmax: sequential argmax over the packed output-layer neuron values.
// The input vector is captured when a classification starts, so upstream
// neurons may change while the scan runs. Values are signed; ties resolve to
// the lowest index. The result (digit, max_value) and result_valid are held
// until the next accepted start; done is a single-cycle pulse.
//
// Handshake: start is a request sampled only while busy is low (IDLE). A start
// seen while busy is dropped, not queued. done pulses for one cycle exactly when
// result_valid rises; result_valid stays high until the next accepted start or reset.
module output_argmax #(
  parameter  int num_classes = 10,
  parameter  int resolution  = 8,
  localparam int index_width = (num_classes > 1) ? $clog2(num_classes) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [resolution*num_classes-1:0] neuron_data,
  output logic                              busy,
  output logic                              done,
  output logic [index_width-1:0]            digit,
  output logic [resolution-1:0]             max_value,
  output logic                              result_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [index_width-1:0] last_idx  = index_width'(num_classes - 1);
  localparam logic [index_width-1:0] first_idx = (num_classes > 1) ? index_width'(1) : '0;

  state_t                              state_q, state_d;
  logic [resolution*num_classes-1:0]   snap_q, snap_d;
  logic [index_width-1:0]              idx_q, idx_d;
  logic signed [resolution-1:0]        best_val_q, best_val_d;
  logic [index_width-1:0]              best_idx_q, best_idx_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                result_valid_q, result_valid_d;
  logic [index_width-1:0]              digit_q, digit_d;
  logic [resolution-1:0]               max_value_q, max_value_d;

  logic signed [resolution-1:0]        cur_val;
  logic                                new_best;

  // State register and all datapath/output flops, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      snap_q         <= '0;
      idx_q          <= '0;
      best_val_q     <= '0;
      best_idx_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      digit_q        <= '0;
      max_value_q    <= '0;
    end else begin
      state_q        <= state_d;
      snap_q         <= snap_d;
      idx_q          <= idx_d;
      best_val_q     <= best_val_d;
      best_idx_q     <= best_idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
      digit_q        <= digit_d;
      max_value_q    <= max_value_d;
    end
  end

  // Next-state logic: IDLE -> SCAN (or straight to DONE for a single class) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_classes == 1) ? S_DONE : S_SCAN;
      S_SCAN:  if (idx_q == last_idx) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Select the snapshot element addressed by the scan index and compare against the running best.
  always_comb begin
    cur_val = '0;
    for (int i = 0; i < num_classes; i++) begin
      if (idx_q == index_width'(i)) cur_val = snap_q[i*resolution +: resolution];
    end
    new_best = (cur_val > best_val_q);
  end

  // Datapath and registered outputs for the current state.
  always_comb begin
    snap_d         = snap_q;
    idx_d          = idx_q;
    best_val_d     = best_val_q;
    best_idx_d     = best_idx_q;
    done_d         = 1'b0;
    result_valid_d = result_valid_q;
    digit_d        = digit_q;
    max_value_d    = max_value_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d         = neuron_data;
          best_val_d     = neuron_data[resolution-1:0];
          best_idx_d     = '0;
          idx_d          = first_idx;
          result_valid_d = 1'b0;
          if (num_classes == 1) begin
            // Class 0 is the whole answer; publish it immediately.
            done_d         = 1'b1;
            result_valid_d = 1'b1;
            digit_d        = '0;
            max_value_d    = neuron_data[resolution-1:0];
          end
        end
      end
      S_SCAN: begin
        if (new_best) begin
          best_val_d = cur_val;
          best_idx_d = idx_q;
        end
        if (idx_q == last_idx) begin
          // Publish from the updated best so the last element is included.
          done_d         = 1'b1;
          result_valid_d = 1'b1;
          digit_d        = new_best ? idx_q : best_idx_q;
          max_value_d    = new_best ? cur_val : best_val_q;
        end else begin
          idx_d = idx_q + index_width'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign digit        = digit_q;
  assign max_value    = max_value_q;
  assign result_valid = result_valid_q;

endmodule
